// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with stall/flush handling and the architectural flags register.
// Optional perf counters (cnt_stall, cnt_flush) are compiled in with `define EX_MEM_PERF_CNT_EN.
module ex_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [1:0]        ex_flags,
  input  logic              ex_is_cmp,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [3:0]        ex_ctrl,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_ready,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic [3:0]        mem_ctrl,
  output logic [1:0]        flags_q,
  output logic [1:0]        flags_fwd
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]       cnt_stall,
  output logic [31:0]       cnt_flush
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sd;
    logic [REG_W-1:0]  rd;
    logic [3:0]        ctrl;
  } payload_t;

  payload_t    r_pl;
  payload_t    w_ex_pl;
  logic        r_valid;
  logic [1:0]  r_flags;
  logic        w_cap;
  logic        w_flag_upd;

  assign w_ex_pl    = '{alu: ex_alu_result, sd: ex_store_data, rd: ex_rd, ctrl: ex_ctrl};
  assign w_cap      = !mem_stall && !flush;
  assign w_flag_upd = ex_valid && ex_is_cmp && w_cap;

  // A stall freezes MEM even when flush is asserted: the older instruction is never killed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pl    <= '0;
    end else if (!mem_stall) begin
      if (flush) begin
        r_valid <= 1'b0;
        r_pl    <= '0;
      end else begin
        r_valid <= ex_valid;
        r_pl    <= w_ex_pl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           r_flags <= 2'b00;
    else if (w_flag_upd) r_flags <= ex_flags;
  end

  assign ex_ready       = !mem_stall;
  assign mem_valid      = r_valid;
  assign mem_alu_result = r_pl.alu;
  assign mem_store_data = r_pl.sd;
  assign mem_rd         = r_pl.rd;
  assign mem_ctrl       = r_pl.ctrl;
  assign flags_q        = r_flags;
  assign flags_fwd      = w_flag_upd ? ex_flags : r_flags;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] r_cnt_stall;
  logic [31:0] r_cnt_flush;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else begin
      if (r_valid && mem_stall && (r_cnt_stall != 32'hFFFF_FFFF))
        r_cnt_stall <= r_cnt_stall + 32'd1;
      if (flush && ex_valid && !mem_stall && (r_cnt_flush != 32'hFFFF_FFFF))
        r_cnt_flush <= r_cnt_flush + 32'd1;
    end
  end

  assign cnt_stall = r_cnt_stall;
  assign cnt_flush = r_cnt_flush;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: directed vector table, reset/stall sequences, randomized run vs. reference model.
module tb_ex_mem_stage_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [1:0]        ex_flags;
  logic              ex_is_cmp;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rd;
  logic [3:0]        ex_ctrl;
  logic              mem_stall;
  logic              flush;
  logic              ex_ready;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [REG_W-1:0]  mem_rd;
  logic [3:0]        mem_ctrl;
  logic [1:0]        flags_q;
  logic [1:0]        flags_fwd;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0]       cnt_stall;
  logic [31:0]       cnt_flush;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_flags(ex_flags), .ex_is_cmp(ex_is_cmp), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .mem_stall(mem_stall), .flush(flush),
    .ex_ready(ex_ready), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_ctrl(mem_ctrl),
    .flags_q(flags_q), .flags_fwd(flags_fwd)
`ifdef EX_MEM_PERF_CNT_EN
    , .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
`endif
  );

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [1:0]  fl;
    logic        cmp;
    logic [31:0] sd;
    logic [3:0]  rd;
    logic [3:0]  ctrl;
    logic        st;
    logic        fsh;
    logic        e_rdy;
    logic [1:0]  e_fwd;
    logic        e_mv;
    logic [31:0] e_alu;
    logic [31:0] e_sd;
    logic [3:0]  e_rd;
    logic [3:0]  e_ctrl;
    logic [1:0]  e_fq;
  } vec_t;

  vec_t tbl[12];

  // Reference state: what the MEM slot and flags register should hold.
  logic        m_valid;
  logic [31:0] m_alu, m_sd;
  logic [3:0]  m_rd, m_ctrl;
  logic [1:0]  m_flags;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [1:0] fl,
                       input logic cmp, input logic [31:0] sd, input logic [3:0] rd,
                       input logic [3:0] ctrl, input logic st, input logic fsh);
    ex_valid = v; ex_alu_result = alu; ex_flags = fl; ex_is_cmp = cmp;
    ex_store_data = sd; ex_rd = rd; ex_ctrl = ctrl; mem_stall = st; flush = fsh;
  endtask

  task automatic chk_mem(input string tag, input logic mv, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [3:0] rd, input logic [3:0] ctrl,
                         input logic [1:0] fq);
    chk({tag, ".mem_valid"}, 64'(mem_valid), 64'(mv));
    chk({tag, ".mem_alu"},   64'(mem_alu_result), 64'(alu));
    chk({tag, ".mem_sd"},    64'(mem_store_data), 64'(sd));
    chk({tag, ".mem_rd"},    64'(mem_rd), 64'(rd));
    chk({tag, ".mem_ctrl"},  64'(mem_ctrl), 64'(ctrl));
    chk({tag, ".flags_q"},   64'(flags_q), 64'(fq));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_mem("reset", 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
`ifdef EX_MEM_PERF_CNT_EN
    chk("reset.cnt_stall", 64'(cnt_stall), 64'd0);
    chk("reset.cnt_flush", 64'(cnt_flush), 64'd0);
`endif
    reset = 1'b0;

    //          v    alu      fl     cmp   sd       rd    ctrl     st    fsh   rdy   fwd    mv    e_alu    e_sd     e_rd  e_ctrl   e_fq
    tbl[0]  = '{1'b1, 32'h07, 2'b00, 1'b0, 32'hA1, 4'd3, 4'b0100, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h07, 32'hA1, 4'd3, 4'b0100, 2'b00};
    tbl[1]  = '{1'b1, 32'h11, 2'b01, 1'b1, 32'hA2, 4'd1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 32'h11, 32'hA2, 4'd1, 4'b0100, 2'b01};
    tbl[2]  = '{1'b1, 32'h22, 2'b10, 1'b0, 32'hA3, 4'd2, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 32'h22, 32'hA3, 4'd2, 4'b0000, 2'b01};
    tbl[3]  = '{1'b1, 32'h33, 2'b10, 1'b1, 32'hA4, 4'd6, 4'b0001, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h22, 32'hA3, 4'd2, 4'b0000, 2'b01};
    tbl[4]  = '{1'b1, 32'h44, 2'b11, 1'b1, 32'hA5, 4'd7, 4'b0010, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h22, 32'hA3, 4'd2, 4'b0000, 2'b01};
    tbl[5]  = '{1'b0, 32'h55, 2'b00, 1'b0, 32'hA6, 4'd8, 4'b1000, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h22, 32'hA3, 4'd2, 4'b0000, 2'b01};
    tbl[6]  = '{1'b1, 32'h66, 2'b00, 1'b0, 32'hA7, 4'd8, 4'b0010, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 32'h66, 32'hA7, 4'd8, 4'b0010, 2'b01};
    tbl[7]  = '{1'b1, 32'h77, 2'b10, 1'b1, 32'hA8, 4'd9, 4'b0100, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h00, 32'h00, 4'd0, 4'b0000, 2'b01};
    tbl[8]  = '{1'b1, 32'h05, 2'b00, 1'b0, 32'hA9, 4'd5, 4'b1000, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 32'h05, 32'hA9, 4'd5, 4'b1000, 2'b01};
    tbl[9]  = '{1'b1, 32'h99, 2'b10, 1'b1, 32'hAA, 4'hA, 4'b0001, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h05, 32'hA9, 4'd5, 4'b1000, 2'b01};
    tbl[10] = '{1'b0, 32'hAB, 2'b10, 1'b1, 32'hB1, 4'd4, 4'b0010, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'hAB, 32'hB1, 4'd4, 4'b0010, 2'b01};
    tbl[11] = '{1'b1, 32'h01, 2'b10, 1'b1, 32'hC0, 4'd1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 32'h01, 32'hC0, 4'd1, 4'b0100, 2'b10};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].alu, tbl[i].fl, tbl[i].cmp, tbl[i].sd, tbl[i].rd,
            tbl[i].ctrl, tbl[i].st, tbl[i].fsh);
      #1;
      chk($sformatf("vec%0d.ex_ready", i), 64'(ex_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.flags_fwd", i), 64'(flags_fwd), 64'(tbl[i].e_fwd));
      @(posedge clk); #1;
      chk_mem($sformatf("vec%0d", i), tbl[i].e_mv, tbl[i].e_alu, tbl[i].e_sd,
              tbl[i].e_rd, tbl[i].e_ctrl, tbl[i].e_fq);
    end

    // Reset mid-stall: load an instruction, stall 4 cycles, then reset while still stalled.
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'h1234, 2'b01, 1'b1, 32'h5678, 4'd5, 4'b0110, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_mem("pre_stall", 1'b1, 32'h1234, 32'h5678, 4'd5, 4'b0110, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'(i), 2'b10, 1'b1, 32'h0, 4'd9, 4'b0001, 1'b1, 1'b0);
      @(posedge clk);
    end
    #1;
    chk_mem("stall4", 1'b1, 32'h1234, 32'h5678, 4'd5, 4'b0110, 2'b01);
`ifdef EX_MEM_PERF_CNT_EN
    chk("stall4.cnt_stall", 64'(cnt_stall), 64'd4);
    chk("stall4.cnt_flush", 64'(cnt_flush), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_mem("reset_in_stall", 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00);
`ifdef EX_MEM_PERF_CNT_EN
    chk("reset_in_stall.cnt_stall", 64'(cnt_stall), 64'd0);
`endif

    // Randomized run against the reference model.
    do_reset();
    m_valid = 1'b0; m_alu = '0; m_sd = '0; m_rd = '0; m_ctrl = '0; m_flags = '0;
    for (int i = 0; i < 400; i++) begin
      logic rst, take;
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      reset = rst;
      drive(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom), 1'($urandom),
            $urandom, 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
      #1;
      take = ex_valid && ex_is_cmp && !mem_stall && !flush;
      if (!rst) begin
        chk("rnd.ex_ready", 64'(ex_ready), 64'(!mem_stall));
        chk("rnd.flags_fwd", 64'(flags_fwd), 64'(take ? ex_flags : m_flags));
      end
      if (rst) begin
        m_valid = 1'b0; m_alu = '0; m_sd = '0; m_rd = '0; m_ctrl = '0; m_flags = '0;
      end else if (!mem_stall) begin
        if (take) m_flags = ex_flags;
        if (flush) begin
          m_valid = 1'b0; m_alu = '0; m_sd = '0; m_rd = '0; m_ctrl = '0;
        end else begin
          m_valid = ex_valid; m_alu = ex_alu_result; m_sd = ex_store_data;
          m_rd = ex_rd; m_ctrl = ex_ctrl;
        end
      end
      @(posedge clk); #1;
      reset = 1'b0;
      chk_mem("rnd", m_valid, m_alu, m_sd, m_rd, m_ctrl, m_flags);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
